rs_dispatch: RTL
================

# rs_dispatch

Reservation-station block for the Tomasulo datapath. Holds issued instructions whose source operands may still be pending. Snoops the common data bus (CDB) for the missing values and hands fully-ready instructions to the execution unit over a valid/ready dispatch port. It drives the same `rs1_data`/`rs2_data`/`func`/`rob_ind`/`rd` bundle that the execution unit consumes, so it is the producing end of that interface.

## Interface
Parameters:
- `DEPTH`, 4: number of station entries (2..8).
- `TAG_W`, 3: ROB tag width; matches `rob_ind`.

Ports:
- `clk1`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries (mispredict/exception).
- `issue_valid`  in  1  issue request.
- `issue_ready`  out  1  at least one free entry.
- `issue_func`  in  4  opcode.
- `issue_rd`  in  4  destination register.
- `issue_rob`  in  TAG_W  ROB index of the instruction.
- `issue_rs1_rdy`, `issue_rs2_rdy`  in  1 each  operand value present.
- `issue_rs1_val`, `issue_rs2_val`  in  8 each  operand value, used when rdy=1.
- `issue_rs1_tag`, `issue_rs2_tag`  in  TAG_W each  producing ROB tag, used when rdy=0.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  tag of the broadcast result.
- `cdb_data`  in  8  broadcast result.
- `disp_valid`  out  1  a ready entry is presented.
- `disp_ready`  in  1  execution unit accepts.
- `rs1_data`, `rs2_data`  out  8 each  operands of the presented entry.
- `func`  out  4  opcode of the presented entry.
- `rd`  out  4  destination of the presented entry.
- `rob_ind`  out  TAG_W  ROB index of the presented entry.
- `occupancy`  out  4  number of busy entries.

## Operation
- Each entry holds: busy, func, rd, rob, and per operand a rdy bit, an 8-bit value and a tag.
- Issue: on `issue_valid && issue_ready`, the lowest-index free entry is written.
  - An operand with rdy=0 whose tag equals `cdb_tag` while `cdb_valid` is set is captured as ready, with the value taken from `cdb_data` (issue-time bypass).
- Snoop: every cycle, each busy entry's non-ready operand whose tag matches a valid CDB broadcast takes `cdb_data` and sets rdy. Both operands of one entry may match at once.
- Selection: among busy entries with both operands ready, one is presented (see Configuration). `disp_valid` is high while such an entry exists.
  - Outputs are combinational from entry state.
  - Outputs are 0 when `disp_valid`=0.
- Dispatch: on `disp_valid && disp_ready`, the presented entry clears busy at the edge.
- Hold rule: while `disp_valid && !disp_ready`, the selection is frozen. The same entry stays presented with stable outputs until accepted, even if an older entry becomes ready.
- `issue_ready` = (occupancy < DEPTH). A slot freed by dispatch in cycle N is issuable in cycle N+1, not N.
- `flush` clears all busy bits and the hold state. Issue and dispatch in the same cycle are discarded. Flush has priority over both.

## Timing
- Reset values:
  - All entries not busy.
  - `issue_ready`=1.
  - `disp_valid`=0.
  - `rs1_data`, `rs2_data`, `func`, `rd`, `rob_ind` = 0.
  - `occupancy`=0.
- Issue with both operands ready in cycle N: `disp_valid` no earlier than cycle N+1.
- CDB match at edge N: the entry is dispatchable from cycle N+1. There is no same-cycle CDB-to-dispatch path.
- Simultaneous issue and dispatch: occupancy unchanged.
- A CDB broadcast for a tag held by no entry is ignored.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Outputs go to reset values without waiting for a clock edge.

## Configuration
- `RS_OLDEST_FIRST_EN` defined:
  - A DEPTH×DEPTH age matrix is maintained on issue and dispatch.
  - Selection presents the oldest ready entry.
- Not defined:
  - Selection presents the lowest-index ready entry.
  - No age state is built.
- The hold rule applies in both builds.

## Test plan
- Reset then idle → `issue_ready`=1, `disp_valid`=0, `occupancy`=0, all data outputs 0.
- Issue func=0000, rd=3, rob=2, rs1=5 ready, rs2=7 ready, with `disp_ready`=1 → next cycle `disp_valid`=1, `rs1_data`=5, `rs2_data`=7, `rob_ind`=2; entry freed the following edge.
- Issue rs1 ready=9, rs2 pending on tag 4; broadcast tag 4 data 0x21 two cycles later → `disp_valid` rises the cycle after the broadcast with `rs2_data`=0x21. Repeat with the broadcast in the issue cycle → captured via bypass.
- Fill all 4 entries with pending operands → `issue_ready`=0. Broadcast the matching tag and dispatch one → `issue_ready`=1 the cycle after dispatch.
- Entries 2 then 0 become ready while `disp_ready`=0 → presented entry held stable until accepted. Ordering of the remaining ready entries: oldest-first with `RS_OLDEST_FIRST_EN`, index 0 first without.
- Assert `flush` with 3 busy entries while `issue_valid`=1 → next cycle `occupancy`=0, `disp_valid`=0, and the issued instruction is not stored.

Source files
------------

// File: rtl/rs_dispatch.sv
// Reservation station: holds issued instructions, snoops the CDB for pending operands and
// dispatches ready entries over a valid/ready port. Optional RS_OLDEST_FIRST_EN selects oldest-ready.
module rs_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_func,
  input  logic [3:0]       issue_rd,
  input  logic [TAG_W-1:0] issue_rob,
  input  logic             issue_rs1_rdy,
  input  logic             issue_rs2_rdy,
  input  logic [7:0]       issue_rs1_val,
  input  logic [7:0]       issue_rs2_val,
  input  logic [TAG_W-1:0] issue_rs1_tag,
  input  logic [TAG_W-1:0] issue_rs2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [7:0]       cdb_data,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [7:0]       rs1_data,
  output logic [7:0]       rs2_data,
  output logic [3:0]       func,
  output logic [3:0]       rd,
  output logic [TAG_W-1:0] rob_ind,
  output logic [3:0]       occupancy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] r1_rdy;
  logic [DEPTH-1:0] r2_rdy;
  logic [3:0]       e_func [DEPTH];
  logic [3:0]       e_rd   [DEPTH];
  logic [TAG_W-1:0] e_rob  [DEPTH];
  logic [7:0]       r1_val [DEPTH];
  logic [7:0]       r2_val [DEPTH];
  logic [TAG_W-1:0] r1_tag [DEPTH];
  logic [TAG_W-1:0] r2_tag [DEPTH];

  logic             hold_valid;
  logic [IDX_W-1:0] hold_idx;

  logic [DEPTH-1:0] rdy_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [3:0]       occ_cnt;
  logic             issue_fire;
  logic             disp_fire;
  logic             byp1;
  logic             byp2;

`ifdef RS_OLDEST_FIRST_EN
  // age[i][j] set means entry i was issued before entry j
  logic [DEPTH-1:0] age [DEPTH];
  logic             oldest;
`endif

  always_comb begin
    occ_cnt  = '0;
    free_idx = '0;
    rdy_vec  = busy & r1_rdy & r2_rdy;
    for (int i = 0; i < DEPTH; i++) occ_cnt = occ_cnt + 4'(busy[i]);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_comb begin
    pick_idx = '0;
    oldest   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = rdy_vec[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && rdy_vec[j] && !age[i][j]) oldest = 1'b0;
      end
      if (oldest) pick_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    pick_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy_vec[i]) pick_idx = IDX_W'(i);
    end
  end
`endif

  // A held entry stays ready until accepted, so |rdy_vec also covers the held case
  always_comb begin
    sel_idx     = hold_valid ? hold_idx : pick_idx;
    disp_valid  = |rdy_vec;
    issue_ready = (occ_cnt < 4'(DEPTH));
    occupancy   = occ_cnt;
    issue_fire  = issue_valid && issue_ready;
    disp_fire   = disp_valid && disp_ready;
    byp1        = !issue_rs1_rdy && cdb_valid && (issue_rs1_tag == cdb_tag);
    byp2        = !issue_rs2_rdy && cdb_valid && (issue_rs2_tag == cdb_tag);
    rs1_data    = '0;
    rs2_data    = '0;
    func        = '0;
    rd          = '0;
    rob_ind     = '0;
    if (disp_valid) begin
      rs1_data = r1_val[sel_idx];
      rs2_data = r2_val[sel_idx];
      func     = e_func[sel_idx];
      rd       = e_rd[sel_idx];
      rob_ind  = e_rob[sel_idx];
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      r1_rdy     <= '0;
      r2_rdy     <= '0;
      hold_valid <= 1'b0;
      hold_idx   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_func[i] <= '0;
        e_rd[i]   <= '0;
        e_rob[i]  <= '0;
        r1_val[i] <= '0;
        r2_val[i] <= '0;
        r1_tag[i] <= '0;
        r2_tag[i] <= '0;
`ifdef RS_OLDEST_FIRST_EN
        age[i]    <= '0;
`endif
      end
    end else if (flush) begin
      busy       <= '0;
      hold_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && !r1_rdy[i] && cdb_valid && r1_tag[i] == cdb_tag) begin
          r1_rdy[i] <= 1'b1;
          r1_val[i] <= cdb_data;
        end
        if (busy[i] && !r2_rdy[i] && cdb_valid && r2_tag[i] == cdb_tag) begin
          r2_rdy[i] <= 1'b1;
          r2_val[i] <= cdb_data;
        end
      end

      if (disp_fire) begin
        busy[sel_idx] <= 1'b0;
        hold_valid    <= 1'b0;
      end else if (disp_valid) begin
        hold_valid <= 1'b1;
        hold_idx   <= sel_idx;
      end

      // The issue slot is never busy, so these writes cannot collide with snoop or dispatch
      if (issue_fire) begin
        busy[free_idx]   <= 1'b1;
        e_func[free_idx] <= issue_func;
        e_rd[free_idx]   <= issue_rd;
        e_rob[free_idx]  <= issue_rob;
        r1_rdy[free_idx] <= issue_rs1_rdy | byp1;
        r2_rdy[free_idx] <= issue_rs2_rdy | byp2;
        r1_val[free_idx] <= byp1 ? cdb_data : issue_rs1_val;
        r2_val[free_idx] <= byp2 ? cdb_data : issue_rs2_val;
        r1_tag[free_idx] <= issue_rs1_tag;
        r2_tag[free_idx] <= issue_rs2_tag;
`ifdef RS_OLDEST_FIRST_EN
        for (int j = 0; j < DEPTH; j++) begin
          age[free_idx][j] <= 1'b0;
          age[j][free_idx] <= (j != int'(free_idx));
        end
`endif
      end
    end
  end

endmodule
